// File: rtl/cipher_loop_ctrl_if.sv
// cipher_loop_ctrl_if: bundles the receiver, transmitter, key-load and
// cipher-core signals of cipher_loop_ctrl.
//   master : the controller (drives send/core/status, observes the rest)
//   slave  : the surrounding receiver/transmitter/core environment
interface cipher_loop_ctrl_if #(
    parameter int BLK_W = 64,
    parameter int KEY_W = 80
);
    // receiver side
    logic             recv_done;
    logic [BLK_W-1:0] recv_data;
    logic             mode_dec;
    // transmitter side
    logic             tx_busy;
    logic             send_en;
    logic [BLK_W-1:0] send_data;
    // run-time key load
    logic             key_wr;
    logic [KEY_W-1:0] key_data;
    // cipher core
    logic             core_start;
    logic             core_dec;
    logic [BLK_W-1:0] core_state;
    logic [KEY_W-1:0] core_key;
    logic             core_ce;
    logic             core_done;
    logic [BLK_W-1:0] core_result;
    // status
    logic             ovf;
    logic             busy;

    modport master (
        input  recv_done, recv_data, mode_dec, tx_busy, key_wr, key_data,
               core_done, core_result,
        output send_en, send_data, core_start, core_dec, core_state, core_key,
               core_ce, ovf, busy
    );

    modport slave (
        output recv_done, recv_data, mode_dec, tx_busy, key_wr, key_data,
               core_done, core_result,
        input  send_en, send_data, core_start, core_dec, core_state, core_key,
               core_ce, ovf, busy
    );
endinterface

// File: rtl/cipher_loop_ctrl.sv
// cipher_loop_ctrl: sequences received blocks through a block-cipher core
// and hands results to a transmitter.
//   sys_clk, sys_rst_n : clock, asynchronous active-low reset
//   bus (master)       : recv_done/recv_data/mode_dec in, tx_busy in,
//                        send_en/send_data out, key_wr/key_data in,
//                        core_start/core_dec/core_state/core_key/core_ce out,
//                        core_done/core_result in, ovf/busy out
// A one-entry pending slot lets a block queue while the core or the
// transmitter is occupied; a second queued block is dropped and flagged.
module cipher_loop_ctrl #(
    parameter int               BLK_W   = 64,
    parameter int               KEY_W   = 80,
    parameter int               CE_DIV  = 100,
    parameter logic [KEY_W-1:0] KEY_RST = {KEY_W{1'b1}},
    parameter bit               BIT_REV = 1'b1
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    cipher_loop_ctrl_if.master bus
);
    localparam int CNT_W = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CE_DIV - 1);

    typedef enum logic [1:0] {IDLE, RUN, WAIT_TX} state_t;

    state_t           state_q, state_d;
    logic             d0, d1, flag;
    logic             slot_full, slot_dec;
    logic [BLK_W-1:0] slot_data;
    logic [KEY_W-1:0] shadow_key, core_key_q;
    logic [BLK_W-1:0] result_q, result_out;
    logic [BLK_W-1:0] core_state_q, send_data_q;
    logic             core_start_q, core_dec_q, send_en_q, ovf_q;
    logic [CNT_W-1:0] ce_cnt;
    logic             ld_core, take_res, do_send;
    logic             slot_accept;

    // Rising-edge detect on the receiver's level signal.
    assign flag = d0 & ~d1;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            d0 <= 1'b0;
            d1 <= 1'b0;
        end else begin
            d0 <= bus.recv_done;
            d1 <= d0;
        end
    end

    // Free-running core clock-enable divider, independent of the FSM.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)             ce_cnt <= '0;
        else if (ce_cnt == CNT_MAX) ce_cnt <= '0;
        else                        ce_cnt <= ce_cnt + CNT_W'(1);
    end

    assign bus.core_ce = (ce_cnt == CNT_MAX);

    // FSM
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state_q <= IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        ld_core  = 1'b0;
        take_res = 1'b0;
        do_send  = 1'b0;
        unique case (state_q)
            IDLE: if (slot_full) begin
                ld_core = 1'b1;
                state_d = RUN;
            end
            RUN: if (bus.core_done) begin
                take_res = 1'b1;
                state_d  = WAIT_TX;
            end
            WAIT_TX: if (!bus.tx_busy) begin
                do_send = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A capture is accepted when the slot is empty or is being drained into
    // the core on this same edge.
    assign slot_accept = flag & (~slot_full | ld_core);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            slot_full <= 1'b0;
            slot_data <= '0;
            slot_dec  <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            if (slot_accept) begin
                slot_full <= 1'b1;
                slot_data <= bus.recv_data;
                slot_dec  <= bus.mode_dec;
            end else if (ld_core) begin
                slot_full <= 1'b0;
            end
            if (flag && !slot_accept) ovf_q <= 1'b1;
        end
    end

    // Key: the shadow takes every write; the core copy follows the shadow
    // only in IDLE, so it is frozen for the whole of a core run. A block
    // started from IDLE picks up the shadow on the same edge core_start rises.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            shadow_key <= KEY_RST;
            core_key_q <= KEY_RST;
        end else begin
            if (bus.key_wr)      shadow_key <= bus.key_data;
            if (state_q == IDLE) core_key_q <= shadow_key;
        end
    end

    // Core and transmit datapath
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            core_start_q <= 1'b0;
            core_dec_q   <= 1'b0;
            core_state_q <= '0;
            result_q     <= '0;
            send_en_q    <= 1'b0;
            send_data_q  <= '0;
        end else begin
            if (ld_core) begin
                core_start_q <= 1'b1;
                core_state_q <= slot_data;
                core_dec_q   <= slot_dec;
            end else if (take_res) begin
                core_start_q <= 1'b0;
            end
            if (take_res) result_q <= bus.core_result;
            send_en_q <= do_send;
            if (do_send) send_data_q <= result_out;
        end
    end

    generate
        if (BIT_REV) begin : g_rev
            for (genvar k = 0; k < BLK_W; k++) begin : g_bit
                assign result_out[BLK_W-1-k] = result_q[k];
            end
        end else begin : g_pass
            assign result_out = result_q;
        end
    endgenerate

    assign bus.send_en    = send_en_q;
    assign bus.send_data  = send_data_q;
    assign bus.core_start = core_start_q;
    assign bus.core_dec   = core_dec_q;
    assign bus.core_state = core_state_q;
    assign bus.core_key   = core_key_q;
    assign bus.ovf        = ovf_q;
    assign bus.busy       = (state_q != IDLE) | slot_full;
endmodule

// File: doc/cipher_loop_ctrl.md
Name: cipher_loop_ctrl

Overview:
Parametrised controller between a UART-style block receiver/transmitter pair and a block-cipher core (PRESENT-class).
- Detects received blocks, queues up to one pending block while the core is busy, and drives the core with a start/done handshake and a clock-enable strobe. It does not generate a derived clock.
- Returns each cipher result to the transmitter, optionally bit-reversed.
- Adds run-time key loading, encrypt/decrypt mode select and a sticky overflow flag.

Parameters:
BLK_W, 64, block width in bits (state, result, recv_data, send_data).
KEY_W, 80, cipher key width in bits.
CE_DIV, 100, core_ce period in sys_clk cycles (>=2).
KEY_RST, {KEY_W{1'b1}}, key value after reset.
BIT_REV, 1, 1 = send_data is bit-reversed result; 0 = pass-through.

Ports:
sys_clk  in  1  system clock.
sys_rst_n  in  1  asynchronous active-low reset.
recv_done  in  1  receiver block-complete level; rising edge = new block.
recv_data  in  BLK_W  received block, valid when the recv_done rising edge is detected.
tx_busy  in  1  transmitter busy.
key_wr  in  1  one-cycle key load strobe.
key_data  in  KEY_W  key value, sampled when key_wr=1.
mode_dec  in  1  0 = encrypt, 1 = decrypt; latched per block at capture.
send_en  out  1  one-cycle transmit start pulse.
send_data  out  BLK_W  transmit block, stable from send_en until the next send_en.
core_start  out  1  core run request, held high until core_done is seen.
core_dec  out  1  mode for the current core operation.
core_state  out  BLK_W  core input block.
core_key  out  KEY_W  core key, frozen while core_start=1.
core_ce  out  1  core clock enable, one cycle high every CE_DIV cycles.
core_done  in  1  core result valid, level.
core_result  in  BLK_W  core output block.
ovf  out  1  sticky overflow: a block was dropped.
busy  out  1  high when state is not IDLE or the pending slot is full.

Behaviour:
- Reset (async, asserted): all outputs 0 except core_key=KEY_RST. FSM in IDLE, pending empty, CE counter 0, edge-detect flops 0.
- Edge detect: recv_done passes through two flops d0 and d1. flag = d0 & ~d1. recv_data is captured on the edge where flag=1, i.e. the 2nd rising edge after recv_done is first sampled high.
- core_ce: free-running counter 0..CE_DIV-1. core_ce=1 in the cycle where count==CE_DIV-1, then the counter wraps to 0. It runs in every state.
- Pending slot, one entry: {data, dec}.
  - Capture with slot empty: fill the slot.
  - Capture with slot full: drop the new block and set ovf=1. ovf clears only on reset.
- Key register:
  - key_wr=1 writes a shadow key.
  - The shadow copies to core_key when core_start=0 (IDLE), otherwise at the IDLE return.
  - key_wr and a capture in the same cycle: the new key applies to that block if it starts from IDLE on the next cycle.
- FSM:
  - IDLE: if the slot is full, load core_state/core_dec from the slot, empty the slot, core_start<=1, go to RUN.
  - RUN: on core_done=1, register core_result into a result register, core_start<=0, go to WAIT_TX.
  - WAIT_TX: on tx_busy=0, send_data <= BIT_REV ? reversed(result) : result, send_en<=1 for one cycle, go to IDLE. "reversed" means send_data[BLK_W-1-k]=result[k].
- Latency: block capture to core_start is 1 cycle. core_done to send_en is 2 cycles when tx_busy=0.
- Captures are accepted in every state, so a new block can queue while RUN or WAIT_TX is in progress. Back-to-back throughput is limited only by the core.
- core_done=1 while in IDLE or WAIT_TX is ignored.
- tx_busy=1 stalls in WAIT_TX indefinitely. send_data does not change during the stall.
- Reset mid-operation aborts immediately. Pending and in-flight blocks are lost, and no send_en is issued.

Test Plan:
1. Use CE_DIV=4, BIT_REV=0, key at reset (all ones) and a behavioural core model returning state^key[63:0] 10 ce strobes after start. Send recv_data=64'h0, rising edge -> core_start=1 one cycle after capture, core_key=80'hFFFF_FFFF_FFFF_FFFF_FFFF, and a single send_en pulse with send_data=64'hFFFF_FFFF_FFFF_FFFF.
2. BIT_REV=1, core echoes state, recv_data=64'h0000_0000_0000_0001 -> send_data=64'h8000_0000_0000_0000.
3. Two blocks (A, B) arrive during RUN of block 0 -> B sets ovf=1. Outputs for block 0 then A are in order, and exactly two further send_en pulses occur.
4. Hold tx_busy=1 for 50 cycles after core_done -> send_en stays 0. send_en pulses on the 1st cycle after tx_busy falls, and send_data is stable through the stall.
5. key_wr with key_data=80'h0 during RUN -> core_key unchanged until IDLE. The next block uses key 0, so the echo model output equals the input.
6. Assert sys_rst_n=0 mid-RUN -> all outputs 0 and core_key=KEY_RST immediately. No send_en occurs after release until a new recv_done edge.
